// File: rtl/booth_nibble_seq_mult_if.sv
// Operand/product handshakes plus the nibble-multiplier side channel of booth_nibble_seq_mult.
// slave = the sequencer, master = whoever feeds operands, takes products and closes the MUL_C loop.
`timescale 1ns/1ps
interface booth_nibble_seq_mult_if #(
  parameter int A_WIDTH = 16
);
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [A_WIDTH-1:0]   IN_A;
  logic [7:0]           IN_B;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [A_WIDTH+7:0]   PRODUCT;
  logic [3:0]           MUL_A;
  logic [7:0]           MUL_B;
  logic [11:0]          MUL_C;

  modport slave (
    input  IN_VALID, IN_A, IN_B, OUT_READY, MUL_C,
    output IN_READY, OUT_VALID, PRODUCT, MUL_A, MUL_B
  );

  modport master (
    output IN_VALID, IN_A, IN_B, OUT_READY, MUL_C,
    input  IN_READY, OUT_VALID, PRODUCT, MUL_A, MUL_B
  );
endinterface

// File: rtl/booth_nibble_seq_mult.sv
// Sequential A_WIDTH x 8 unsigned multiplier: one A nibble per cycle through an external
// 4x8 combinational multiplier, shift-accumulated into an (A_WIDTH+8)-bit product.
`timescale 1ns/1ps
module booth_nibble_seq_mult #(
  parameter int A_WIDTH    = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  booth_nibble_seq_mult_if.slave bus
);
  localparam int NIB = A_WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int PW  = A_WIDTH + 8;
  localparam int SW  = CW + 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      product_q, product_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [3:0]         mul_a_q, mul_a_d;
  logic [7:0]         mul_b_q, mul_b_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SW-1:0]      sh_cur, sh_nxt;
  logic [A_WIDTH-1:0] a_shr;
  logic [PW-1:0]      term, acc_sum;
  logic               last;

  // MUL_A/MUL_B are registered, so the nibble for the next pass is selected one cycle early.
  assign sh_cur  = SW'({cnt_q, 2'b00});
  assign sh_nxt  = sh_cur + SW'(4);
  assign a_shr   = a_q >> sh_nxt;
  assign term    = PW'(bus.MUL_C) << sh_cur;
  assign acc_sum = acc_q + term;
  assign last    = (cnt_q == CW'(NIB - 1)) || (EARLY_EXIT && (a_shr == '0));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    product_d   = product_q;
    a_d         = a_q;
    b_d         = b_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          a_d        = bus.IN_A;
          b_d        = bus.IN_B;
          acc_d      = '0;
          cnt_d      = '0;
          mul_a_d    = bus.IN_A[3:0];
          mul_b_d    = bus.IN_B;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          product_d   = acc_sum;
          out_valid_d = 1'b1;
          mul_a_d     = '0;
          mul_b_d     = '0;
          state_d     = DONE;
        end else begin
          mul_a_d = a_shr[3:0];
        end
      end
      DONE: begin
        if (bus.OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.PRODUCT   = product_q;
  assign bus.MUL_A     = mul_a_q;
  assign bus.MUL_B     = mul_b_q;
endmodule
